d_sram_axi_bridge: RTL and testbench

Data-side bridge between the MIPS pipeline's SRAM-like data-memory port (MEM stage) and the AXI master interface of the SoC. It converts one CPU load/store into a single-beat AXI read or write. It generates d_stall, which the hazard unit consumes, and it uses the hazard unit's all_stall to keep a completed access from being re-issued while the pipeline is frozen by another source, such as i_stall.

---
 rtl/d_sram_axi_bridge.sv | 181 ++++++++++++++++++
 tb/tb_d_sram_axi_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/d_sram_axi_bridge.sv
// Data-side SRAM-like to AXI bridge: turns one MEM-stage load/store into a single-beat
// AXI read or write, stalls the pipeline until it completes, and holds the result while frozen.
module d_sram_axi_bridge #(
   parameter logic [3:0] AXI_ID = 4'h1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        data_en,
   input  logic [3:0]  data_wen,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        d_stall,
   input  logic        all_stall,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [7:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_e;

   state_e      state_q, state_d;
   logic        finish_q, finish_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  size_q, size_d;
   logic [3:0]  strb_q, strb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        req;
   logic        aw_hs;
   logic        w_hs;

   // finish blocks re-issue of the same instruction until the pipeline moves on
   assign req     = data_en & ~finish_q;
   assign d_stall = req;

   assign arid    = AXI_ID;
   assign awid    = AXI_ID;
   assign arlen   = '0;
   assign awlen   = '0;
   assign arburst = 2'b01;
   assign awburst = 2'b01;
   assign arlock  = '0;
   assign awlock  = '0;
   assign arcache = '0;
   assign awcache = '0;
   assign arprot  = '0;
   assign awprot  = '0;

   assign araddr  = addr_q;
   assign awaddr  = addr_q;
   assign arsize  = {1'b0, size_q};
   assign awsize  = {1'b0, size_q};
   assign wdata   = wdata_q;
   assign wstrb   = strb_q;

   assign arvalid = (state_q == RADDR);
   assign rready  = (state_q == RDATA);
   assign awvalid = (state_q == WADDR) & ~aw_done_q;
   assign wvalid  = (state_q == WADDR) & ~w_done_q;
   assign wlast   = wvalid;
   assign bready  = (state_q == WRESP);

   assign data_rdata = rdata_q;
   assign aw_hs      = awvalid & awready;
   assign w_hs       = wvalid & wready;

   always_comb begin
      state_d   = state_q;
      finish_d  = finish_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      size_d    = size_q;
      strb_d    = strb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;

      if (finish_q && !all_stall) begin
         finish_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (req) begin
               addr_d    = data_addr;
               size_d    = data_size;
               strb_d    = data_wen;
               wdata_d   = data_wdata;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = (data_wen == '0) ? RADDR : WADDR;
            end
         end
         RADDR: begin
            if (arready) begin
               state_d = RDATA;
            end
         end
         RDATA: begin
            if (rvalid) begin
               rdata_d  = rdata;
               finish_d = 1'b1;
               state_d  = IDLE;
            end
         end
         WADDR: begin
            // AW and W complete independently; leave once both have been accepted
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WRESP;
            end
         end
         WRESP: begin
            if (bvalid) begin
               finish_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         finish_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         size_q    <= '0;
         strb_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         finish_q  <= finish_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         size_q    <= size_d;
         strb_q    <= strb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// Bench for d_sram_axi_bridge: directed and random loads/stores against an AXI slave
// with programmable per-channel delays and a transaction-level expectation model.
module tb_d_sram_axi_bridge;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        data_en = 1'b0;
   logic [3:0]  data_wen = '0;
   logic [1:0]  data_size = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [31:0] data_rdata;
   logic        d_stall;
   logic        i_stall = 1'b0;
   logic        all_stall;
   logic [3:0]  arid, awid;
   logic [31:0] araddr, awaddr;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock;
   logic [3:0]  arcache, awcache;
   logic        arvalid, rready, awvalid, wvalid, wlast, bready;
   logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] last_rd = '0;

   always #5 aclk = ~aclk;
   assign all_stall = i_stall | d_stall;

   d_sram_axi_bridge #(.AXI_ID(4'h1)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .data_en(data_en), .data_wen(data_wen), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .d_stall(d_stall), .all_stall(all_stall),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pipeline frozen by another source after completion, then released.
   task automatic hold_then_release(input int unsigned hold);
      i_stall = (hold > 0);
      for (int unsigned k = 1; k <= hold; k++) begin
         @(negedge aclk);
         chk("hold_d_stall", {31'b0, d_stall}, 32'd0);
         chk("hold_no_valid", {30'b0, arvalid, awvalid}, 32'd0);
         chk("hold_rdata", data_rdata, last_rd);
         i_stall = (k < hold);
      end
      @(negedge aclk);
      #1 chk("finish_cleared", {31'b0, d_stall}, 32'd1);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] rd,
                          input int unsigned ard, input int unsigned rdl, input int unsigned hold);
      int unsigned ar_seen = 0, r_seen = 0, ar_hs = 0, r_hs = 0, cyc = 0;
      bit done = 0, aw_flag = 0;
      data_en = 1'b1; data_wen = '0; data_addr = addr; data_size = sz; data_wdata = $urandom;
      #1 chk("rd_stall_start", {31'b0, d_stall}, 32'd1);
      while (!done && cyc < 64) begin
         @(negedge aclk);
         cyc++;
         arready = 1'b0; rvalid = 1'b0;
         if (d_stall !== 1'b1) begin
            done = 1;
         end else begin
            if (awvalid || wvalid || bready) aw_flag = 1;
            if (arvalid) begin arready = (ar_seen >= ard); ar_seen++; end
            if (rready) begin
               rvalid = (r_seen >= rdl);
               rdata  = rvalid ? rd : $urandom;
               r_seen++;
            end
            #1;
            if (arvalid && arready) begin
               ar_hs++;
               chk("araddr", araddr, addr);
               chk("arsize", {29'b0, arsize}, {30'b0, sz});
            end
            if (rvalid && rready) r_hs++;
         end
      end
      chk("rd_latency", cyc, 3 + ard + rdl);
      chk("ar_handshakes", ar_hs, 1);
      chk("r_handshakes", r_hs, 1);
      chk("rd_no_write_chan", {31'b0, aw_flag}, 32'd0);
      chk("rd_data", data_rdata, rd);
      chk("rd_arvalid_low", {31'b0, arvalid}, 32'd0);
      last_rd = rd;
      hold_then_release(hold);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [1:0] sz, input logic [3:0] wen,
                           input logic [31:0] wd, input int unsigned awd, input int unsigned wdl,
                           input int unsigned bd, input int unsigned hold);
      int unsigned aw_seen = 0, w_seen = 0, b_seen = 0, aw_hs = 0, w_hs = 0, b_hs = 0, cyc = 0;
      int unsigned mx;
      bit done = 0, ar_flag = 0, early_b = 0;
      mx = (awd > wdl) ? awd : wdl;
      data_en = 1'b1; data_wen = wen; data_addr = addr; data_size = sz; data_wdata = wd;
      #1 chk("wr_stall_start", {31'b0, d_stall}, 32'd1);
      while (!done && cyc < 64) begin
         @(negedge aclk);
         cyc++;
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
         if (d_stall !== 1'b1) begin
            done = 1;
         end else begin
            if (arvalid || rready) ar_flag = 1;
            if (bready && !(aw_hs == 1 && w_hs == 1)) early_b = 1;
            chk("wlast_eq_wvalid", {31'b0, wlast}, {31'b0, wvalid});
            if (awvalid) begin awready = (aw_seen >= awd); aw_seen++; end
            if (wvalid) begin wready = (w_seen >= wdl); w_seen++; end
            if (bready) begin bvalid = (b_seen >= bd); b_seen++; end
            #1;
            if (awvalid && awready) begin
               aw_hs++;
               chk("awaddr", awaddr, addr);
               chk("awsize", {29'b0, awsize}, {30'b0, sz});
            end
            if (wvalid && wready) begin
               w_hs++;
               chk("wdata", wdata, wd);
               chk("wstrb", {28'b0, wstrb}, {28'b0, wen});
            end
            if (bvalid && bready) b_hs++;
         end
      end
      chk("wr_latency", cyc, 3 + mx + bd);
      chk("aw_handshakes", aw_hs, 1);
      chk("w_handshakes", w_hs, 1);
      chk("b_handshakes", b_hs, 1);
      chk("bready_before_both", {31'b0, early_b}, 32'd0);
      chk("wr_no_read_chan", {31'b0, ar_flag}, 32'd0);
      chk("wr_rdata_kept", data_rdata, last_rd);
      hold_then_release(hold);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  wen;
      logic [1:0]  sz;
      // reset state
      #12;
      chk("rst_valids", {26'b0, arvalid, awvalid, wvalid, rready, bready, wlast}, 32'd0);
      chk("rst_rdata", data_rdata, 32'd0);
      chk("rst_d_stall", {31'b0, d_stall}, 32'd0);
      chk("rst_ids", {24'b0, arid, awid}, 32'h11);
      chk("rst_len_burst", {12'b0, arlen, awlen, arburst, awburst}, 32'h5);
      chk("rst_ties", {10'b0, arlock, awlock, arcache, awcache, arprot, awprot}, 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;

      do_read(32'h1FC0_0010, 2'd2, 32'hDEADBEEF, 1, 1, 0);
      do_write(32'h8000_0002, 2'd0, 4'b0100, 32'h00AB_0000, 1, 1, 1, 0);
      do_write(32'h8000_1000, 2'd2, 4'b1111, 32'h1234_5678, 3, 0, 2, 0);
      do_write(32'h8000_1004, 2'd1, 4'b0011, 32'h0000_BEEF, 0, 3, 2, 0);
      do_write(32'h8000_1008, 2'd1, 4'b1100, 32'hCAFE_0000, 0, 0, 0, 0);
      do_read(32'h8000_2000, 2'd2, 32'h0BAD_F00D, 0, 0, 5);
      do_read(32'h8000_3001, 2'd0, 32'h0000_5A00, 0, 2, 0);
      do_write(32'h8000_3002, 2'd1, 4'b1100, 32'h7777_0000, 0, 0, 0, 0);

      // asynchronous reset while waiting for read data
      data_en = 1'b1; data_wen = '0; data_addr = 32'h8000_4000; data_size = 2'd2;
      @(negedge aclk);
      chk("rst6_arvalid", {31'b0, arvalid}, 32'd1);
      arready = 1'b1;
      @(negedge aclk);
      arready = 1'b0;
      chk("rst6_rready", {31'b0, rready}, 32'd1);
      @(negedge aclk);
      #2 aresetn = 1'b0;
      #1;
      chk("rst6_valids", {26'b0, arvalid, awvalid, wvalid, rready, bready, wlast}, 32'd0);
      chk("rst6_rdata", data_rdata, 32'd0);
      chk("rst6_d_stall_en", {31'b0, d_stall}, 32'd1);
      data_en = 1'b0;
      #1 chk("rst6_d_stall_off", {31'b0, d_stall}, 32'd0);
      last_rd = '0;
      @(negedge aclk);
      aresetn = 1'b1;
      do_read(32'h8000_4000, 2'd2, 32'h600D_0001, 0, 0, 0);

      for (int i = 0; i < 24; i++) begin
         sz = 2'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 0) begin
            do_read($urandom, sz, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
         end else begin
            case (sz)
               2'd0:    wen = 4'b0001 << $urandom_range(0, 3);
               2'd1:    wen = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1100;
               default: wen = 4'b1111;
            endcase
            do_write($urandom, sz, wen, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
         end
      end

      data_en = 1'b0;
      repeat (3) @(negedge aclk);
      chk("end_idle", {30'b0, arvalid, awvalid}, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
